// File: rtl/mxv_result_collector_if.sv
// Handshake bundle between the inner-product unit, the result collector and its consumer.
// Optional max-tracking signals exist only when MXV_COLLECT_MAX_EN is defined.
`default_nettype none

interface mxv_result_collector_if #(
  parameter int RES_WIDTH = 7,
  parameter int NUM_ROWS  = 3
);
  logic [RES_WIDTH-1:0]          in_data;
  logic                          in_valid;
  logic                          in_last;
  logic                          in_ready;
  logic                          clear;
  logic [NUM_ROWS*RES_WIDTH-1:0] out_vec;
  logic                          out_valid;
  logic                          out_ready;
  logic                          frame_err;
`ifdef MXV_COLLECT_MAX_EN
  logic [RES_WIDTH-1:0]          max_val;
  logic [$clog2(NUM_ROWS)-1:0]   max_row;
`endif

  modport master (
    output in_data, in_valid, in_last, clear, out_ready,
`ifdef MXV_COLLECT_MAX_EN
    input  max_val, max_row,
`endif
    input  in_ready, out_vec, out_valid, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, clear, out_ready,
`ifdef MXV_COLLECT_MAX_EN
    output max_val, max_row,
`endif
    output in_ready, out_vec, out_valid, frame_err
  );
endinterface

`default_nettype wire

// File: rtl/mxv_result_collector.sv
// ---------------------------------------------------------------------------
// mxv_result_collector : packs one inner-product result per row into a vector
// Optional feature macro: MXV_COLLECT_MAX_EN (largest result + row tracking)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mxv_result_collector #(
  parameter int DATA_WIDTH = 2,
  parameter int NUM_ELEMS  = 5,
  parameter int NUM_ROWS   = 3
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  mxv_result_collector_if.slave bus
);

  localparam int RES_WIDTH = 2*DATA_WIDTH + $clog2(NUM_ELEMS+1);
  localparam int ROW_W     = $clog2(NUM_ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS-1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t               state;
  logic [ROW_W-1:0]     row_cnt;
  logic [RES_WIDTH-1:0] slots [NUM_ROWS];
  logic                 accept_en;
  logic                 vec_valid;
  logic                 err_flag;
`ifdef MXV_COLLECT_MAX_EN
  logic [RES_WIDTH-1:0] max_val_q;
  logic [ROW_W-1:0]     max_row_q;
`endif

  logic take;
  logic row_is_last;
  assign take        = bus.in_valid && accept_en;
  assign row_is_last = (row_cnt == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      row_cnt   <= '0;
      slots     <= '{default: '0};
      accept_en <= 1'b1;
      vec_valid <= 1'b0;
      err_flag  <= 1'b0;
`ifdef MXV_COLLECT_MAX_EN
      max_val_q <= '0;
      max_row_q <= '0;
`endif
    end else if (bus.clear) begin
      state     <= COLLECT;
      row_cnt   <= '0;
      slots     <= '{default: '0};
      accept_en <= 1'b1;
      vec_valid <= 1'b0;
      err_flag  <= 1'b0;
`ifdef MXV_COLLECT_MAX_EN
      max_val_q <= '0;
      max_row_q <= '0;
`endif
    end else begin
      case (state)
        COLLECT: begin
          if (take) begin
            slots[row_cnt] <= bus.in_data;
`ifdef MXV_COLLECT_MAX_EN
            // Strict compare so equal values keep the earlier (lower) row.
            if (bus.in_data > max_val_q) begin
              max_val_q <= bus.in_data;
              max_row_q <= row_cnt;
            end
`endif
            if (bus.in_last || row_is_last) begin
              state     <= HOLD;
              accept_en <= 1'b0;
              vec_valid <= 1'b1;
              err_flag  <= !(bus.in_last && row_is_last);
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        HOLD: begin
          // in_ready stays low through the handshake cycle: one idle input slot per vector.
          if (bus.out_ready) begin
            state     <= COLLECT;
            row_cnt   <= '0;
            slots     <= '{default: '0};
            accept_en <= 1'b1;
            vec_valid <= 1'b0;
            err_flag  <= 1'b0;
`ifdef MXV_COLLECT_MAX_EN
            max_val_q <= '0;
            max_row_q <= '0;
`endif
          end
        end
        default: begin
          state     <= COLLECT;
          row_cnt   <= '0;
          accept_en <= 1'b1;
          vec_valid <= 1'b0;
          err_flag  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_pack
    assign bus.out_vec[r*RES_WIDTH +: RES_WIDTH] = slots[r];
  end

  assign bus.in_ready  = accept_en;
  assign bus.out_valid = vec_valid;
  assign bus.frame_err = err_flag;
`ifdef MXV_COLLECT_MAX_EN
  assign bus.max_val   = max_val_q;
  assign bus.max_row   = max_row_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mxv_result_collector.sv
// Scoreboard bench for mxv_result_collector: directed vectors, expected vectors queued
// at issue time and checked by an independent monitor at each output handshake.
`default_nettype none

module tb_mxv_result_collector;

  localparam int RW    = 7;
  localparam int NR    = 3;
  localparam int VEC_W = NR*RW;

  typedef struct {
    logic [VEC_W-1:0] vec;
    logic             err;
    logic [RW-1:0]    mval;
    logic [1:0]       mrow;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t q[$];
  exp_t mon_e;

  mxv_result_collector_if #(.RES_WIDTH(RW), .NUM_ROWS(NR)) bus ();

  mxv_result_collector #(.DATA_WIDTH(2), .NUM_ELEMS(5), .NUM_ROWS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] mk(input int r0, input int r1, input int r2);
    logic [RW-1:0] a, b, c;
    a = RW'(r0); b = RW'(r1); c = RW'(r2);
    return {c, b, a};
  endfunction

  task automatic expect_vec(input int r0, input int r1, input int r2, input logic err,
                            input int mv, input int mr);
    exp_t e;
    e.vec = mk(r0, r1, r2); e.err = err; e.mval = RW'(mv); e.mrow = 2'(mr);
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input logic last);
    int n;
    bus.in_data = RW'(d); bus.in_last = last; bus.in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (q.size() != 0 && n < 50);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && !bus.clear && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", bus.out_vec);
      end else begin
        mon_e = q.pop_front();
        chk("sb_out_vec", 64'(bus.out_vec), 64'(mon_e.vec));
        chk("sb_frame_err", 64'(bus.frame_err), 64'(mon_e.err));
`ifdef MXV_COLLECT_MAX_EN
        chk("sb_max_val", 64'(bus.max_val), 64'(mon_e.mval));
        chk("sb_max_row", 64'(bus.max_row), 64'(mon_e.mrow));
`endif
      end
    end
  end

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    bus.clear = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_vec", 64'(bus.out_vec), 64'd0);
    chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
    @(posedge clk); #1;

    // Nominal
    bus.out_ready = 1'b1;
    expect_vec(5, 12, 40, 1'b0, 40, 2);
    send(5, 1'b0); send(12, 1'b0); send(40, 1'b1);
    @(negedge clk);
    chk("nom_in_ready_low", 64'(bus.in_ready), 64'd0);
    chk("nom_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("nom_post_out_valid", 64'(bus.out_valid), 64'd0);
    chk("nom_post_out_vec", 64'(bus.out_vec), 64'd0);
    chk("nom_post_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Backpressure with input pressure in HOLD
    bus.out_ready = 1'b0;
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b1);
    bus.in_valid = 1'b1; bus.in_data = RW'(99);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_vec_stable", 64'(bus.out_vec), 64'(mk(1, 2, 3)));
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    expect_vec(1, 2, 3, 1'b0, 3, 2);
    bus.out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("bp_back_collect", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Early last
    expect_vec(7, 3, 0, 1'b1, 7, 0);
    send(7, 1'b0); send(3, 1'b1);
    drain();

    // Missing last
    expect_vec(10, 20, 30, 1'b1, 30, 2);
    send(10, 1'b0); send(20, 1'b0); send(30, 1'b0);
    drain();

    // Clear mid-collection, coincident input discarded
    send(11, 1'b0); send(22, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = RW'(50); bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_vec", 64'(bus.out_vec), 64'd0);
    chk("clr_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    expect_vec(1, 2, 3, 1'b0, 3, 2);
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b1);
    drain();

    // Clear in HOLD beats a coincident output handshake
    bus.out_ready = 1'b0;
    send(4, 1'b0); send(5, 1'b0); send(6, 1'b1);
    @(negedge clk);
    chk("clrh_out_valid", 64'(bus.out_valid), 64'd1);
    @(posedge clk); #1;
    bus.clear = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    chk("clrh_out_valid_low", 64'(bus.out_valid), 64'd0);
    chk("clrh_out_vec", 64'(bus.out_vec), 64'd0);
    chk("clrh_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // Asynchronous reset in HOLD
    send(1, 1'b0); send(2, 1'b0); send(3, 1'b1);
    @(negedge clk);
    chk("arst_pre_out_valid", 64'(bus.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_out_vec", 64'(bus.out_vec), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Tie on the maximum keeps the lower row
    expect_vec(9, 40, 40, 1'b0, 40, 1);
    send(9, 1'b0); send(40, 1'b0); send(40, 1'b1);
    drain();

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
